// File: rtl/msk_tx_framer.sv
// msk_tx_framer: frame builder and bit serializer feeding the msk_mod
// data_in/data_in_val pair. A frame is a preamble, a sync word,
// PAYLOAD_LEN words pulled from an AXI-stream input, then an optional
// idle gap. Bits leave MSB first, each held for SPS clocks.
// Optional feature: define MSK_TX_PRBS_EN to add a PRBS-15 payload
// source selected per frame by the prbs_mode input.
module msk_tx_framer #(
    parameter int          DATA_W      = 8,
    parameter int          SPS         = 20,
    parameter int          PRE_LEN     = 32,
    parameter logic [31:0] PREAMBLE    = 32'hFFFFFFFF,
    parameter int          SYNC_LEN    = 16,
    parameter logic [31:0] SYNC_WORD   = 32'h00001A01,
    parameter int          PAYLOAD_LEN = 16,
    parameter int          GAP_BITS    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
`ifdef MSK_TX_PRBS_EN
    input  logic              prbs_mode,
`endif
    output logic              s_tready,
    output logic              data_out,
    output logic              data_val,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    // Counter widths cover the terminal value of each counter.
    localparam int TMR_W  = $clog2(SPS);
    localparam int MAXB_A = (PRE_LEN > SYNC_LEN) ? PRE_LEN : SYNC_LEN;
    localparam int MAXB_B = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
    localparam int MAXB   = (MAXB_A > MAXB_B) ? MAXB_A : MAXB_B;
    localparam int BIT_W  = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int WRD_W  = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    // One MSB-aligned shift register serves preamble, sync and payload.
    localparam int SH_W   = (DATA_W > 32) ? DATA_W : 32;

    localparam logic [TMR_W-1:0] T_LAST    = TMR_W'(SPS - 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
    localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(SYNC_LEN - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [WRD_W-1:0] WRD_LAST  = WRD_W'(PAYLOAD_LEN - 1);

    // Only the LEN least significant bits of each pattern are sent, so
    // the pattern is shifted up until its bit LEN-1 sits at the MSB.
    localparam logic [SH_W-1:0] PRE_INIT  =
        (PRE_LEN > 0) ? (SH_W'(PREAMBLE) << (SH_W - PRE_LEN)) : '0;
    localparam logic [SH_W-1:0] SYNC_INIT = SH_W'(SYNC_WORD) << (SH_W - SYNC_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_PAY,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WRD_W-1:0]  wrd_q, wrd_d;
    logic [SH_W-1:0]   sh_q, sh_d;

    logic              last_tick;
    logic              start_ok;
    logic              start_go;
    logic              fetch;
    logic              decide;
    logic              prbs_sel;
    logic              prbs_bit;
    logic              in_field;

`ifdef MSK_TX_PRBS_EN
    logic [14:0]       prbs_q;
    logic              prbs_act_q;

    // In PRBS mode a frame needs no stream data to start.
    assign start_ok = enable & (prbs_mode | s_tvalid);
    assign prbs_sel = prbs_act_q;
    assign prbs_bit = prbs_q[14];

    // PRBS-15 (x^15+x^14+1): mode latched per frame, state kept across frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            prbs_q     <= 15'h7FFF;
            prbs_act_q <= 1'b0;
        end else begin
            if (start_go) begin
                prbs_act_q <= prbs_mode;
            end
            if (state_q == S_PAY && last_tick && prbs_act_q) begin
                prbs_q <= {prbs_q[13:0], prbs_q[14] ^ prbs_q[13]};
            end
        end
    end
`else
    assign start_ok = enable & s_tvalid;
    assign prbs_sel = 1'b0;
    assign prbs_bit = 1'b0;
`endif

    assign last_tick = (tmr_q == T_LAST);
    assign in_field  = (state_q == S_PRE) || (state_q == S_SYNC) || (state_q == S_PAY);

    assign busy     = (state_q != S_IDLE);
    assign data_val = in_field && (tmr_q == '0);
    assign data_out = (state_q == S_PAY && prbs_sel) ? prbs_bit :
                      in_field ? sh_q[SH_W-1] : 1'b0;

    // Next-state, counters, shift register and the single-cycle strobes.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        bit_d      = bit_q;
        wrd_d      = wrd_q;
        sh_d       = sh_q;
        s_tready   = 1'b0;
        underrun   = 1'b0;
        frame_done = 1'b0;
        start_go   = 1'b0;
        fetch      = 1'b0;
        decide     = 1'b0;

        if (state_q != S_IDLE) begin
            tmr_d = last_tick ? '0 : tmr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    start_go = 1'b1;
                end
            end
            S_PRE: begin
                if (last_tick) begin
                    if (bit_q == PRE_LAST) begin
                        state_d = S_SYNC;
                        bit_d   = '0;
                        sh_d    = SYNC_INIT;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {sh_q[SH_W-2:0], 1'b0};
                    end
                end
            end
            S_SYNC: begin
                if (last_tick) begin
                    if (bit_q == SYNC_LAST) begin
                        state_d = S_PAY;
                        bit_d   = '0;
                        wrd_d   = '0;
                        fetch   = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {sh_q[SH_W-2:0], 1'b0};
                    end
                end
            end
            S_PAY: begin
                if (last_tick) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (wrd_q == WRD_LAST) begin
                            frame_done = 1'b1;
                            if (GAP_BITS > 0) begin
                                state_d = S_GAP;
                            end else begin
                                decide = 1'b1;
                            end
                        end else begin
                            wrd_d = wrd_q + 1'b1;
                            fetch = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {sh_q[SH_W-2:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                if (last_tick) begin
                    if (bit_q == GAP_LAST) begin
                        decide = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // End of frame: chain straight into the next one or fall back to IDLE.
        if (decide) begin
            if (start_ok) begin
                start_go = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (start_go) begin
            state_d = (PRE_LEN > 0) ? S_PRE : S_SYNC;
            tmr_d   = '0;
            bit_d   = '0;
            sh_d    = (PRE_LEN > 0) ? PRE_INIT : SYNC_INIT;
        end

        // A missing word is replaced by zeros; bit timing carries on untouched.
        if (fetch && !prbs_sel) begin
            if (s_tvalid) begin
                s_tready = 1'b1;
                sh_d     = SH_W'(s_tdata) << (SH_W - DATA_W);
            end else begin
                underrun = 1'b1;
                sh_d     = '0;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            wrd_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            wrd_q   <= wrd_d;
        end
    end

    // Serializer data path; outputs are gated by state so it needs no reset.
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

endmodule

// File: tb/tb_msk_tx_framer.sv
// tb_msk_tx_framer: directed bench for msk_tx_framer. Several instances
// with different parameter sets share one stimulus bus; sel chooses the
// instance that is enabled and observed.
module tb_msk_tx_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        prbs_mode = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic [3:0] o_rdy, o_out, o_val, o_busy, o_done, o_und;
    logic       obs_rdy, obs_out, obs_val, obs_busy, obs_done, obs_und;

    always #5 clk = ~clk;

    msk_tx_framer u0 (
        .clk(clk), .reset(reset), .enable(enable && sel == 2'd0),
        .s_tdata(s_tdata[7:0]), .s_tvalid(s_tvalid),
`ifdef MSK_TX_PRBS_EN
        .prbs_mode(1'b0),
`endif
        .s_tready(o_rdy[0]), .data_out(o_out[0]), .data_val(o_val[0]),
        .busy(o_busy[0]), .frame_done(o_done[0]), .underrun(o_und[0])
    );

    msk_tx_framer #(.GAP_BITS(4)) u1 (
        .clk(clk), .reset(reset), .enable(enable && sel == 2'd1),
        .s_tdata(s_tdata[7:0]), .s_tvalid(s_tvalid),
`ifdef MSK_TX_PRBS_EN
        .prbs_mode(1'b0),
`endif
        .s_tready(o_rdy[1]), .data_out(o_out[1]), .data_val(o_val[1]),
        .busy(o_busy[1]), .frame_done(o_done[1]), .underrun(o_und[1])
    );

    msk_tx_framer #(.SPS(2), .DATA_W(16), .PRE_LEN(0), .PAYLOAD_LEN(4)) u2 (
        .clk(clk), .reset(reset), .enable(enable && sel == 2'd2),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid),
`ifdef MSK_TX_PRBS_EN
        .prbs_mode(1'b0),
`endif
        .s_tready(o_rdy[2]), .data_out(o_out[2]), .data_val(o_val[2]),
        .busy(o_busy[2]), .frame_done(o_done[2]), .underrun(o_und[2])
    );

`ifdef MSK_TX_PRBS_EN
    msk_tx_framer #(.PAYLOAD_LEN(2)) u3 (
        .clk(clk), .reset(reset), .enable(enable && sel == 2'd3),
        .s_tdata(s_tdata[7:0]), .s_tvalid(s_tvalid),
        .prbs_mode(prbs_mode),
        .s_tready(o_rdy[3]), .data_out(o_out[3]), .data_val(o_val[3]),
        .busy(o_busy[3]), .frame_done(o_done[3]), .underrun(o_und[3])
    );
`else
    assign o_rdy[3]  = 1'b0;
    assign o_out[3]  = 1'b0;
    assign o_val[3]  = 1'b0;
    assign o_busy[3] = 1'b0;
    assign o_done[3] = 1'b0;
    assign o_und[3]  = 1'b0;
`endif

    assign obs_rdy  = o_rdy[sel];
    assign obs_out  = o_out[sel];
    assign obs_val  = o_val[sel];
    assign obs_busy = o_busy[sel];
    assign obs_done = o_done[sel];
    assign obs_und  = o_und[sel];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_t = 0;
    int          done_t = 0;
    int          n_rdy, n_und, n_done;
    int          slot;
    int          drop_idx = 3;
    logic        drop_en = 1'b0;
    logic        src_off = 1'b0;
    logic [5:0]  last_vec;
    logic [15:0] words [0:63];
    logic        bits [$];
    int          vt [$];
    int          rt [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        s_tdata  = words[slot % 64];
        s_tvalid = !src_off && !(drop_en && slot == drop_idx);
    endtask

    // One clock: sample the observed instance mid-cycle, then update the source.
    task automatic step();
        @(negedge clk);
        cyc++;
        last_vec = {obs_out, obs_val, obs_busy, obs_rdy, obs_done, obs_und};
        if (!obs_busy && enable && (s_tvalid || prbs_mode)) start_t = cyc;
        if (obs_val) begin
            bits.push_back(obs_out);
            vt.push_back(cyc);
        end
        if (obs_rdy) begin
            n_rdy++;
            rt.push_back(cyc);
        end
        if (obs_und) n_und++;
        if (obs_done) begin
            n_done++;
            done_t = cyc;
        end
        if (obs_rdy || obs_und) slot++;
        @(posedge clk);
        #1;
        drive_src();
    endtask

    task automatic clr();
        bits.delete();
        vt.delete();
        rt.delete();
        n_rdy  = 0;
        n_und  = 0;
        n_done = 0;
        slot   = 0;
        drive_src();
    endtask

    task automatic do_reset();
        enable = 1'b0;
        reset  = 1'b1;
        step();
        step();
        reset = 1'b0;
        clr();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0 = n_done;
        int k = 0;
        while (n_done == n0 && k < budget) begin
            step();
            k++;
        end
        if (n_done == n0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (obs_busy && k < budget) begin
            step();
            k++;
        end
        chk(tag, {31'd0, obs_busy}, 32'd0);
    endtask

    task automatic wait_val(input string tag, input int budget, output int t);
        int n0 = vt.size();
        int k = 0;
        while (vt.size() == n0 && k < budget) begin
            step();
            k++;
        end
        if (vt.size() == n0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            t = -1;
        end else begin
            t = vt[n0];
        end
    endtask

    // Packs n captured bits starting at off, first captured bit ends up as MSB.
    task automatic get_field(input int off, input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (off + i < bits.size()) v = {v[30:0], bits[off + i]};
            else v = {v[30:0], 1'b0};
        end
    endtask

    // Counts payload words of the default 8-bit frame that differ from the table.
    task automatic bad_words(input int base, input logic skip3, output int bad);
        logic [31:0] v;
        logic [7:0]  e;
        bad = 0;
        for (int w = 0; w < 16; w++) begin
            get_field(base + 8 * w, 8, v);
            e = (skip3 && w == 3) ? 8'h00 : words[w][7:0];
            if (v[7:0] != e) bad++;
        end
    endtask

    task automatic bad_period(input int sps, output int bad);
        bad = 0;
        for (int i = 1; i < vt.size(); i++) begin
            if (vt[i] - vt[i-1] != sps) bad++;
        end
    endtask

    task automatic fill8();
        words[0] = 16'h0090;
        words[1] = 16'h0010;
        for (int i = 2; i < 64; i++) words[i] = 16'((i - 2) & 8'hFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int bad;
        int t;

        fill8();
        clr();

        // Reset state of the default instance.
        sel = 2'd0;
        do_reset();
        chk("reset_outputs", {26'd0, last_vec}, 32'd0);

        // Nominal frame, enable dropped early: frame still completes.
        enable = 1'b1;
        repeat (5) step();
        enable = 1'b0;
        wait_done("t2_done", 5000);
        wait_idle("t2_idle", 50);
        chk("t2_bitcount", 32'(bits.size()), 32'd176);
        chk("t2_latency", 32'(vt.size() > 0 ? vt[0] - start_t : -1), 32'd1);
        bad_period(20, bad);
        chk("t2_period", 32'(bad), 32'd0);
        get_field(0, 32, v);
        chk("t2_preamble", v, 32'hFFFFFFFF);
        get_field(32, 16, v);
        chk("t2_sync", v, 32'h00001A01);
        get_field(48, 8, v);
        chk("t2_word0", v, 32'h00000090);
        bad_words(48, 1'b0, bad);
        chk("t2_payload", 32'(bad), 32'd0);
        chk("t2_done_time", 32'(vt.size() > 0 ? done_t - vt[0] : -1), 32'd3519);
        chk("t2_tready_cnt", 32'(n_rdy), 32'd16);
        chk("t2_underrun_cnt", 32'(n_und), 32'd0);
        chk("t2_done_cnt", 32'(n_done), 32'd1);

        // Word 3 missing from the stream.
        do_reset();
        drop_en = 1'b1;
        drive_src();
        enable = 1'b1;
        repeat (5) step();
        enable = 1'b0;
        wait_done("t3_done", 5000);
        wait_idle("t3_idle", 50);
        drop_en = 1'b0;
        chk("t3_underrun_cnt", 32'(n_und), 32'd1);
        chk("t3_tready_cnt", 32'(n_rdy), 32'd15);
        get_field(48 + 24, 8, v);
        chk("t3_word3", v, 32'd0);
        bad_words(48, 1'b1, bad);
        chk("t3_payload", 32'(bad), 32'd0);

        // Back-to-back frames with no gap: next bit one clock after frame_done.
        do_reset();
        enable = 1'b1;
        wait_done("t4_done1", 5000);
        wait_val("t4_next", 200, t);
        if (t >= 0) chk("t4_b2b_gap0", 32'(t - done_t), 32'd1);
        enable = 1'b0;
        wait_done("t4_done2", 5000);
        wait_idle("t4_idle", 50);
        chk("t4_done_cnt", 32'(n_done), 32'd2);
        get_field(176, 32, v);
        chk("t4_preamble2", v, 32'hFFFFFFFF);

        // Four idle bit periods (80 clocks) between frame_done and the next bit.
        sel = 2'd1;
        do_reset();
        enable = 1'b1;
        wait_done("t5_done1", 5000);
        wait_val("t5_next", 200, t);
        if (t >= 0) chk("t5_b2b_gap4", 32'(t - done_t), 32'd81);
        enable = 1'b0;
        wait_done("t5_done2", 5000);
        wait_idle("t5_idle", 200);

        // Reset mid-payload aborts the frame; a fresh full frame follows.
        sel = 2'd0;
        do_reset();
        enable = 1'b1;
        begin
            int k = 0;
            while (bits.size() < 60 && k < 3000) begin
                step();
                k++;
            end
        end
        chk("t6_midframe_busy", {31'd0, obs_busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_abort_done", 32'(n_done), 32'd0);
        clr();
        step();
        chk("t6_outputs_after_reset", {26'd0, last_vec}, 32'd0);
        repeat (5) step();
        enable = 1'b0;
        wait_done("t6_done", 5000);
        wait_idle("t6_idle", 50);
        chk("t6_done_cnt", 32'(n_done), 32'd1);
        chk("t6_bitcount", 32'(bits.size()), 32'd176);
        get_field(0, 32, v);
        chk("t6_preamble", v, 32'hFFFFFFFF);
        bad_words(48, 1'b0, bad);
        chk("t6_payload", 32'(bad), 32'd0);

        // SPS=2, 16-bit words, no preamble.
        sel = 2'd2;
        words[0] = 16'hA5C3;
        words[1] = 16'h0F01;
        words[2] = 16'h8000;
        words[3] = 16'h7FFE;
        do_reset();
        enable = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        wait_done("t7_done", 500);
        wait_idle("t7_idle", 20);
        chk("t7_bitcount", 32'(bits.size()), 32'd80);
        chk("t7_latency", 32'(vt.size() > 0 ? vt[0] - start_t : -1), 32'd1);
        chk("t7_first_bit", {31'd0, bits.size() > 0 ? bits[0] : 1'b1}, 32'd0);
        get_field(0, 16, v);
        chk("t7_sync", v, 32'h00001A01);
        bad = 0;
        for (int w = 0; w < 4; w++) begin
            get_field(16 + 16 * w, 16, v);
            if (v[15:0] != words[w]) bad++;
        end
        chk("t7_payload", 32'(bad), 32'd0);
        bad_period(2, bad);
        chk("t7_period", 32'(bad), 32'd0);
        chk("t7_tready_cnt", 32'(n_rdy), 32'd4);
        bad = 0;
        for (int i = 1; i < rt.size(); i++) if (rt[i] - rt[i-1] != 32) bad++;
        chk("t7_word_spacing", 32'(bad), 32'd0);
        fill8();

`ifdef MSK_TX_PRBS_EN
        // PRBS payload: needs no stream data, continues across frames.
        sel = 2'd3;
        do_reset();
        src_off   = 1'b1;
        prbs_mode = 1'b1;
        drive_src();
        enable = 1'b1;
        wait_done("t8_done1", 3000);
        enable    = 1'b0;
        prbs_mode = 1'b0;
        wait_done("t8_done2", 3000);
        wait_idle("t8_idle", 50);
        chk("t8_bitcount", 32'(bits.size()), 32'd128);
        get_field(48, 16, v);
        chk("t8_prbs_frame1", v, 32'h0000FFFE);
        get_field(112, 16, v);
        chk("t8_prbs_frame2", v, 32'h00000004);
        chk("t8_tready_cnt", 32'(n_rdy), 32'd0);
        chk("t8_underrun_cnt", 32'(n_und), 32'd0);
        src_off = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
